// File: rtl/ode_mem_pkg.sv
// Shared constants for the solver RAM and its requesters.
// Contents:
//   ADDRESS_WIDTH / DATA_WIDTH  geometry of the solver RAM
//   N_REQ                       number of RAM requesters
//   REQ_HOST / REQ_INTERP / REQ_EULER  requester indices on the packed buses
//   arb_state_t                 arbiter state encoding
package ode_mem_pkg;

    localparam int ADDRESS_WIDTH = 13;
    localparam int DATA_WIDTH    = 64;
    localparam int N_REQ         = 3;

    localparam int REQ_HOST   = 0;
    localparam int REQ_INTERP = 1;
    localparam int REQ_EULER  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin find-first-set.
// The scan starts at PTR+1 and wraps, so the requester at PTR is the
// last one considered.
// Ports:
//   REQ     in   N   request vector
//   PTR     in   PW  index of the most recent grant
//   VALID   out  1   at least one request bit set
//   INDEX   out  PW  index of the selected request
//   ONEHOT  out  N   one-hot form of INDEX (all zero when !VALID)
module rr_pick
    import ode_mem_pkg::*;
#(
    parameter int N  = N_REQ,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  REQ,
    input  logic [PW-1:0] PTR,
    output logic          VALID,
    output logic [PW-1:0] INDEX,
    output logic [N-1:0]  ONEHOT
);

    always_comb begin
        VALID  = 1'b0;
        INDEX  = '0;
        ONEHOT = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(PTR) + k) % N;
            if (!VALID && REQ[j]) begin
                VALID     = 1'b1;
                INDEX     = PW'(j);
                ONEHOT[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner arbitration for the shared solver RAM.
// A single owner at a time drives the RAM address/data/write-enable pins.
// Read data goes straight from the RAM to every requester; RD_VALID tells
// each requester when that data belongs to it.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ, LOCK, WR_EN         per-requester request, burst lock, write strobe
//   RD_ADD1, RD_ADD2, WR_ADD packed per-requester addresses
//   WR_DATA                  packed per-requester write data
//   GNT, RD_VALID            registered one-hot grant / read-data ownership
//   OWNER, BUSY              registered grant index / any grant active
//   RAM_*                    RAM pins, muxed from the current owner
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no grant; arbitrate every cycle
// ST_OWNED | GNT[OWNER]=1; hold while locked, under burst cap
module ram_port_arbiter
    import ode_mem_pkg::*;
#(
    parameter int N_REQ         = ode_mem_pkg::N_REQ,
    parameter int ADDRESS_WIDTH = ode_mem_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = ode_mem_pkg::DATA_WIDTH,
    parameter int MAX_BURST     = 8,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_REQ-1:0]               REQ,
    input  logic [N_REQ-1:0]               LOCK,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0] RD_ADD1,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0] RD_ADD2,
    input  logic [N_REQ-1:0]               WR_EN,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0] WR_ADD,
    input  logic [N_REQ*DATA_WIDTH-1:0]    WR_DATA,
    output logic [N_REQ-1:0]               GNT,
    output logic [N_REQ-1:0]               RD_VALID,
    output logic [PW-1:0]                  OWNER,
    output logic                           BUSY,
    output logic [ADDRESS_WIDTH-1:0]       RAM_ADD_RD1,
    output logic [ADDRESS_WIDTH-1:0]       RAM_ADD_RD2,
    output logic [ADDRESS_WIDTH-1:0]       RAM_ADD_WR,
    output logic [DATA_WIDTH-1:0]          RAM_DATA_WR,
    output logic                           RAM_ENABLE_WR
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    burst_cnt;

    logic             pick_valid;
    logic [PW-1:0]    pick_index;
    logic [N_REQ-1:0] pick_onehot;

    logic             cnt_top;
    logic [CW-1:0]    cnt_next;
    logic             contested;
    logic             release_now;
    logic             owner_act;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .REQ    (REQ),
        .PTR    (ptr),
        .VALID  (pick_valid),
        .INDEX  (pick_index),
        .ONEHOT (pick_onehot)
    );

    assign cnt_top   = (burst_cnt == CW'(MAX_BURST - 1));
    assign cnt_next  = cnt_top ? burst_cnt : burst_cnt + 1'b1;
    assign contested = |(REQ & ~GNT);
    assign release_now = (state == ST_OWNED) &&
                         (!REQ[OWNER] || !LOCK[OWNER] || (cnt_top && contested));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            GNT       <= '0;
            RD_VALID  <= '0;
            OWNER     <= '0;
            BUSY      <= 1'b0;
            burst_cnt <= '0;
            ptr       <= PW'(N_REQ - 1);
        end else begin
            RD_VALID <= GNT & REQ;
            if (state == ST_IDLE || release_now) begin
                if (pick_valid) begin
                    state <= ST_OWNED;
                    GNT   <= pick_onehot;
                    OWNER <= pick_index;
                    BUSY  <= 1'b1;
                    ptr   <= pick_index;
                    // A sole requester re-granted to itself keeps counting
                    // so its burst count saturates instead of restarting.
                    if (state == ST_OWNED && pick_index == OWNER)
                        burst_cnt <= cnt_next;
                    else
                        burst_cnt <= '0;
                end else begin
                    state     <= ST_IDLE;
                    GNT       <= '0;
                    OWNER     <= '0;
                    BUSY      <= 1'b0;
                    burst_cnt <= '0;
                end
            end else begin
                burst_cnt <= cnt_next;
            end
        end
    end

    // The grant only drives the RAM while the owner still asserts REQ, so
    // an owner that drops REQ mid-cycle can never write.
    assign owner_act = GNT[OWNER] & REQ[OWNER];

    always_comb begin
        RAM_ADD_RD1   = '0;
        RAM_ADD_RD2   = '0;
        RAM_ADD_WR    = '0;
        RAM_DATA_WR   = '0;
        RAM_ENABLE_WR = 1'b0;
        if (owner_act) begin
            RAM_ADD_RD1   = RD_ADD1[OWNER*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            RAM_ADD_RD2   = RD_ADD2[OWNER*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            RAM_ADD_WR    = WR_ADD[OWNER*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            RAM_DATA_WR   = WR_DATA[OWNER*DATA_WIDTH +: DATA_WIDTH];
            RAM_ENABLE_WR = WR_EN[OWNER] & ~RST;
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single solver RAM (2 read ports, 1 write port, 13-bit address, 64-bit data) among N requesters: host init loader, interpolator and Euler sequencer.
- Performs round-robin arbitration with request/grant handshake, optional locked bursts and a burst-length cap.
- Drives the RAM address, write-data and write-enable pins directly.
- Read data goes from the RAM to all requesters in parallel, not through this block; the arbiter only tags ownership through RD_VALID.

Parameters:
- N_REQ, 3, number of requesters (index 0 = host, 1 = interpolator, 2 = Euler)
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM data width
- MAX_BURST, 8, maximum consecutive granted cycles while others wait (≥1)

Ports:
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous active-high reset
- REQ  in  N_REQ  per-requester access request, level
- LOCK  in  N_REQ  hold grant across cycles while REQ stays high
- RD_ADD1  in  N_REQ*ADDRESS_WIDTH  packed read address, port 1
- RD_ADD2  in  N_REQ*ADDRESS_WIDTH  packed read address, port 2
- WR_EN  in  N_REQ  per-requester write request for the current cycle
- WR_ADD  in  N_REQ*ADDRESS_WIDTH  packed write address
- WR_DATA  in  N_REQ*DATA_WIDTH  packed write data
- GNT  out  N_REQ  registered one-hot grant
- RD_VALID  out  N_REQ  one-hot; RAM read data of the previous granted cycle is valid for this owner
- OWNER  out  $clog2(N_REQ)  index of current grant holder (0 when idle)
- BUSY  out  1  any GNT bit high
- RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR  out  ADDRESS_WIDTH  to RAM
- RAM_DATA_WR  out  DATA_WIDTH  to RAM
- RAM_ENABLE_WR  out  1  to RAM

Behaviour:
- Reset (RST high at posedge):
  - GNT=0, RD_VALID=0, burst counter=0, round-robin pointer=N_REQ-1 (requester 0 has top priority first).
  - RAM_ENABLE_WR is gated by !RST combinationally, so no RAM write occurs in any cycle where RST is high, including mid-burst.
- States:
  - IDLE (GNT=0).
  - OWNED(i) (GNT[i]=1).
  - Next state is computed combinationally and registered at posedge.
- Grant release: the owner i releases at the posedge when any of these holds:
  - REQ[i]=0;
  - REQ[i]=1 and LOCK[i]=0 (single-cycle access);
  - burst counter = MAX_BURST-1 and any other REQ is high.
- Re-arbitration:
  - On release, or from IDLE, the new owner is the first REQ bit scanning from pointer+1 upward with wrap.
  - The new grant is registered at the same edge, so handover has zero bubble.
  - Pointer := index granted. No REQ → IDLE.
- Sole requester: a releasing owner whose REQ is still high and has no competitor is re-granted immediately.
- Burst counter:
  - Resets to 0 on every new grant.
  - Increments each OWNED cycle.
  - Saturates at MAX_BURST-1 when uncontested.
- Latency: REQ rising from IDLE → GNT high after exactly 1 posedge.
- Datapath mux (combinational from registered GNT):
  - If GNT[i] & REQ[i]: RAM_ADD_RD1/RD2/WR and RAM_DATA_WR are taken from slice i, and RAM_ENABLE_WR = WR_EN[i] & !RST.
  - Otherwise all address/data outputs are 0 and RAM_ENABLE_WR = 0. A requester dropping REQ while granted therefore never writes.
- RD_VALID: registered; RD_VALID[i] = GNT[i] & REQ[i] of the previous cycle. It is cleared by reset. The RAM read latency is 1 cycle.
- WR_EN from non-owners is ignored. There is no error output.
- Simultaneous REQ from all requesters after reset grants in order 0,1,2,0,…
- OWNER is the binary encoding of GNT.
- BUSY = |GNT.

Decomposition:
- Package ode_mem_pkg: ADDRESS_WIDTH, DATA_WIDTH, N_REQ, and requester-ID constants REQ_HOST=0, REQ_INTERP=1, REQ_EULER=2.
- Sub-module rr_pick: combinational find-first-set starting after a pointer with wrap; inputs REQ and pointer, outputs valid, index and one-hot.
- All registers, burst counter and packed-bus mux stay in the top-level block.

Test Plan:
- Reset → REQ=3'b111 with LOCK=0: GNT is 001, 010, 100, 001 on consecutive cycles; RD_VALID follows one cycle later; OWNER is 0,1,2,0.
- Locked burst:
  - REQ[2]=1, LOCK[2]=1, WR_EN[2]=1, WR_ADD=7, WR_DATA=64'h15.
  - After 2 cycles, REQ[0] rises.
  - GNT[2] stays high for 8 total cycles, then GNT=001 at the next edge.
  - RAM_ENABLE_WR=1 with RAM_ADD_WR=7 only during the cycles GNT[2] is high.
- Sole requester: REQ=3'b010, LOCK=0 for 12 cycles → GNT=010 continuously and the burst counter saturates without a bubble.
- Non-owner write blocked: GNT=001 and WR_EN=3'b110 with WR_ADD[1]=11 → RAM_ENABLE_WR=0 and RAM_ADD_WR=0.
- Owner drop: GNT[1]=1 while REQ[1] falls mid-cycle → RAM_ENABLE_WR=0 immediately, GNT cleared at the next edge, RD_VALID[1]=0 the following cycle.
- Reset mid-burst: RST high during GNT[2] with WR_EN[2]=1 → RAM_ENABLE_WR=0 in that cycle; after the edge GNT=0 and RD_VALID=0; the first grant after reset goes to requester 0 when REQ=3'b101.
